// File: rtl/rice_param_selector.sv
// Buffers a partition of residuals in a ping-pong RAM and accumulates folded magnitudes.
// Replays each closed partition headed by a change strobe carrying the chosen Rice parameter.
module rice_param_selector #(
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned PART_LOG2 = 12,
  parameter int unsigned MAX_PARAM = 14
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic                iValid,
  input  logic [SAMPLE_W-1:0] iSample,
  input  logic                iFlush,
  output logic                oReady,
  output logic                oValid,
  output logic [SAMPLE_W-1:0] oSample,
  output logic [3:0]          oRiceParam,
  output logic                oChangeParam,
  output logic                oDone
);

  localparam int unsigned N    = 1 << PART_LOG2;
  localparam int unsigned SumW = SAMPLE_W + PART_LOG2;
  localparam int unsigned LenW = PART_LOG2 + 1;

  typedef enum logic [1:0] {StIdle, StAnnounce, StPlay} rd_state_e;

  // Storage: bank index is the address MSB.
  logic [SAMPLE_W-1:0] mem_q [2*N];
  logic [SAMPLE_W-1:0] rdata_q;

  // Fill side
  logic                 fill_bank_q, fill_bank_d;
  logic [PART_LOG2-1:0] cnt_q, cnt_d;
  logic [SumW-1:0]      sum_q, sum_d;

  // Per-bank closure info
  logic [1:0]           pending_q, pending_d;
  logic [1:0][SumW-1:0] bank_sum_q, bank_sum_d;
  logic [1:0][LenW-1:0] bank_len_q, bank_len_d;
  logic [1:0]           bank_flush_q, bank_flush_d;

  // Read side
  rd_state_e            state_q, state_d;
  logic                 rd_bank_q, rd_bank_d;
  logic                 rd_next_q, rd_next_d;
  logic [PART_LOG2-1:0] rd_cnt_q, rd_cnt_d;
  logic [3:0]           param_q, param_d;
  logic                 change_q, change_d;
  logic                 done_q, done_d;

  logic [1:0]           busy;
  logic                 ready;
  logic                 accept;
  logic                 close;
  logic [SAMPLE_W-1:0]  fold;
  logic [LenW-1:0]      cnt_ext;
  logic [SumW-1:0]      sum_ext;
  logic                 last;
  logic                 take;
  logic [PART_LOG2-1:0] rd_addr;
  logic [SumW-1:0]      mean;
  int unsigned          lg_m;
  int unsigned          k_raw;

  function automatic int unsigned floor_log2(input logic [SumW-1:0] v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < int'(SumW); i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

  // A bank is busy while waiting for replay or while the read side owns it.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      busy[b] = pending_q[b] | ((state_q != StIdle) && (rd_bank_q == 1'(b)));
    end
  end

  assign ready   = ~busy[fill_bank_q];
  assign accept  = iValid & ready;
  assign fold    = {iSample[SAMPLE_W-2:0], 1'b0} ^ {SAMPLE_W{iSample[SAMPLE_W-1]}};
  assign cnt_ext = {1'b0, cnt_q} + LenW'(accept);
  assign sum_ext = sum_q + (accept ? SumW'(fold) : SumW'(0));
  assign close   = (accept && (cnt_q == {PART_LOG2{1'b1}})) || (iFlush && (cnt_ext != '0));

  always_comb begin
    fill_bank_d  = fill_bank_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    bank_sum_d   = bank_sum_q;
    bank_len_d   = bank_len_q;
    bank_flush_d = bank_flush_q;
    if (close) begin
      bank_sum_d[fill_bank_q]   = sum_ext;
      bank_len_d[fill_bank_q]   = cnt_ext;
      bank_flush_d[fill_bank_q] = (cnt_ext != LenW'(N));
      fill_bank_d               = ~fill_bank_q;
      cnt_d                     = '0;
      sum_d                     = '0;
    end else if (accept) begin
      cnt_d = cnt_q + PART_LOG2'(1);
      sum_d = sum_ext;
    end
  end

  // Parameter for the bank the read side will take next.
  always_comb begin
    lg_m  = floor_log2(SumW'(bank_len_q[rd_next_q]));
    mean  = bank_sum_q[rd_next_q] >> lg_m;
    k_raw = floor_log2(mean);
    if (k_raw > MAX_PARAM) k_raw = MAX_PARAM;
  end

  assign last = (state_q == StPlay) &&
                ({1'b0, rd_cnt_q} == (bank_len_q[rd_bank_q] - LenW'(1)));
  assign take = pending_q[rd_next_q] && ((state_q == StIdle) || last);

  always_comb begin
    pending_d = pending_q;
    if (take)  pending_d[rd_next_q]   = 1'b0;
    if (close) pending_d[fill_bank_q] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_next_d = rd_next_q;
    rd_cnt_d  = rd_cnt_q;
    param_d   = param_q;
    change_d  = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: ;
      StAnnounce: begin
        state_d  = StPlay;
        rd_cnt_d = '0;
      end
      StPlay: begin
        if (last) begin
          done_d  = bank_flush_q[rd_bank_q];
          state_d = StIdle;
        end else begin
          rd_cnt_d = rd_cnt_q + PART_LOG2'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (take) begin
      state_d   = StAnnounce;
      rd_bank_d = rd_next_q;
      rd_next_d = ~rd_next_q;
      param_d   = 4'(k_raw);
      change_d  = 1'b1;
    end
  end

  assign rd_addr = (state_q == StAnnounce) ? '0 : rd_cnt_q + PART_LOG2'(1);

  always_ff @(posedge iClock) begin
    if (accept) mem_q[{fill_bank_q, cnt_q}] <= iSample;
    rdata_q <= mem_q[{rd_bank_q, rd_addr}];
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      fill_bank_q  <= 1'b0;
      cnt_q        <= '0;
      sum_q        <= '0;
      pending_q    <= '0;
      bank_sum_q   <= '0;
      bank_len_q   <= '0;
      bank_flush_q <= '0;
      state_q      <= StIdle;
      rd_bank_q    <= 1'b0;
      rd_next_q    <= 1'b0;
      rd_cnt_q     <= '0;
      param_q      <= '0;
      change_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      fill_bank_q  <= fill_bank_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      pending_q    <= pending_d;
      bank_sum_q   <= bank_sum_d;
      bank_len_q   <= bank_len_d;
      bank_flush_q <= bank_flush_d;
      state_q      <= state_d;
      rd_bank_q    <= rd_bank_d;
      rd_next_q    <= rd_next_d;
      rd_cnt_q     <= rd_cnt_d;
      param_q      <= param_d;
      change_q     <= change_d;
      done_q       <= done_d;
    end
  end

  assign oReady       = ready;
  assign oValid       = (state_q == StPlay);
  assign oSample      = oValid ? rdata_q : '0;
  assign oRiceParam   = param_q;
  assign oChangeParam = change_q;
  assign oDone        = done_q;

endmodule
